// File: rtl/fuente_pixeles_pkg.sv
// Shared types for the pixel source: frame FSM states and the dimension width
// used by the image size and position counters.
package fuente_pixeles_pkg;

    localparam int ANCHO_DIM = 10;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVO,
        FIN
    } estado_t;

    typedef logic [ANCHO_DIM-1:0] dim_t;

endpackage

// File: rtl/fifo_pixeles.sv
// First-word-fall-through pixel FIFO with a registered head, fill count and
// full/empty flags. Pointers wrap naturally because the depth is a power of two.
module fifo_pixeles #(
    parameter int PROFUNDIDAD = 16,
    parameter int ANCHO_PIXEL = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ANCHO_PIXEL-1:0]         din,
    input  logic                           push,
    input  logic                           pop,
    output logic [ANCHO_PIXEL-1:0]         dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(PROFUNDIDAD):0]   count
);

    localparam int AP = $clog2(PROFUNDIDAD);

    logic [ANCHO_PIXEL-1:0] mem [PROFUNDIDAD];
    logic [AP-1:0]          wr_ptr;
    logic [AP-1:0]          rd_ptr;
    logic [AP-1:0]          rd_ptr_next;
    logic [AP:0]            count_next;
    logic [ANCHO_PIXEL-1:0] head_next;
    logic                   push_ok;
    logic                   pop_ok;

    assign full    = (count == (AP+1)'(PROFUNDIDAD));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a write when a pop frees the head slot this cycle.
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        rd_ptr_next = rd_ptr;
        count_next  = count;
        head_next   = dout;
        if (pop_ok)
            rd_ptr_next = rd_ptr + AP'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + (AP+1)'(1);
            2'b01:   count_next = count - (AP+1)'(1);
            default: count_next = count;
        endcase
        // The incoming pixel becomes the head when it lands in the slot being exposed.
        if (count_next != '0)
            head_next = (push_ok && (wr_ptr == rd_ptr_next)) ? din : mem[rd_ptr_next];
    end

    // NOTE: storage is not reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AP'(1);
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            dout   <= head_next;
        end
    end

endmodule

// File: rtl/fuente_pixeles.sv
// Pixel source: buffers upstream pixels and serves exactly one frame of
// ancho x alto pixels per iniciar, tracking the column/row of the next pixel.
module fuente_pixeles
    import fuente_pixeles_pkg::*;
#(
    parameter int PROFUNDIDAD = 16,
    parameter int ANCHO_PIXEL = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ANCHO_PIXEL-1:0]         pixel_in,
    input  logic                           write_pixel,
    input  logic                           iniciar,
    input  logic [ANCHO_DIM-1:0]           ancho_imagen,
    input  logic [ANCHO_DIM-1:0]           alto_imagen,
    input  logic                           read_pixel,
    output logic [ANCHO_PIXEL-1:0]         pixel_entrada,
    output logic                           data_available,
    output logic                           fifo_full,
    output logic [$clog2(PROFUNDIDAD):0]   ocupacion,
    output logic [ANCHO_DIM-1:0]           columna,
    output logic [ANCHO_DIM-1:0]           fila,
    output logic                           frame_done,
    output logic                           ocupado,
    output logic                           overflow,
    output logic                           underflow
);

    estado_t estado;
    estado_t estado_next;
    dim_t    ancho_q;
    dim_t    alto_q;
    logic    vacio;
    logic    pop_ok;
    logic    fin_columna;
    logic    ultimo_pixel;

    fifo_pixeles #(
        .PROFUNDIDAD (PROFUNDIDAD),
        .ANCHO_PIXEL (ANCHO_PIXEL)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .din   (pixel_in),
        .push  (write_pixel),
        .pop   (pop_ok),
        .dout  (pixel_entrada),
        .full  (fifo_full),
        .empty (vacio),
        .count (ocupacion)
    );

    assign data_available = (estado == ACTIVO) && !vacio;
    assign pop_ok         = read_pixel && data_available;
    assign fin_columna    = (columna == ancho_q - dim_t'(1));
    assign ultimo_pixel   = fin_columna && (fila == alto_q - dim_t'(1));
    assign frame_done     = (estado == FIN);
    assign ocupado        = (estado != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            estado <= IDLE;
        else
            estado <= estado_next;
    end

    always_comb begin
        estado_next = estado;
        case (estado)
            IDLE:    if (iniciar) estado_next = ACTIVO;
            ACTIVO:  if (pop_ok && ultimo_pixel) estado_next = FIN;
            FIN:     estado_next = IDLE;
            default: estado_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ancho_q   <= '0;
            alto_q    <= '0;
            columna   <= '0;
            fila      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Dimensions are latched only when a frame actually starts.
            if (estado == IDLE && iniciar) begin
                ancho_q <= ancho_imagen;
                alto_q  <= alto_imagen;
                columna <= '0;
                fila    <= '0;
            end
            if (pop_ok) begin
                if (fin_columna) begin
                    columna <= '0;
                    fila    <= ultimo_pixel ? '0 : fila + dim_t'(1);
                end else begin
                    columna <= columna + dim_t'(1);
                end
            end
            if (write_pixel && fifo_full && !pop_ok)
                overflow <= 1'b1;
            if (read_pixel && !data_available)
                underflow <= 1'b1;
        end
    end

endmodule

// File: doc/fuente_pixeles.md
FUENTE_PIXELES -- requirements
Module: fuente_pixeles

Interface
REQ-001 Parameter PROFUNDIDAD, default 16, FIFO depth in pixels, power of two, 4..256.
REQ-002 Parameter ANCHO_PIXEL, default 8, pixel width in bits.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pixel_in  input  ANCHO_PIXEL  upstream pixel to store.
REQ-007 write_pixel  input  1  upstream write strobe, one pixel per cycle.
REQ-008 iniciar  input  1  one-cycle pulse, starts serving a frame.
REQ-009 ancho_imagen  input  10  frame width in pixels, 1..1023, sampled on accepted iniciar.
REQ-010 alto_imagen  input  10  frame height in rows, 1..1023, sampled on accepted iniciar.
REQ-011 read_pixel  input  1  pop request from the window generator.
REQ-012 pixel_entrada  output  ANCHO_PIXEL  FIFO head, first-word-fall-through, feeds the window generator.
REQ-013 data_available  output  1  head valid and frame active.
REQ-014 fifo_full  output  1  FIFO holds PROFUNDIDAD pixels.
REQ-015 ocupacion  output  log2(PROFUNDIDAD)+1  current fill count.
REQ-016 columna, fila  output  10 each  position of the next pixel to be served.
REQ-017 frame_done  output  1  one-cycle pulse after the last frame pixel is popped.
REQ-018 ocupado  output  1  high outside IDLE.
REQ-019 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-020 States: IDLE, ACTIVO, FIN; ACTIVO on iniciar in IDLE; FIN after last pop; FIN -> IDLE next cycle unconditionally.
REQ-021 iniciar in ACTIVO or FIN is ignored; sampled dimensions stay unchanged.
REQ-022 Writes are accepted in every state (prefill before iniciar allowed).
REQ-023 write_pixel with fifo_full low: pixel stored at tail, ocupacion +1 next cycle.
REQ-024 write_pixel with fifo_full high and read_pixel not accepted: pixel dropped, overflow set.
REQ-025 data_available = (state==ACTIVO) and (ocupacion!=0), combinational from registered state.
REQ-026 read_pixel with data_available high: pop accepted; pixel_entrada shows next entry the following cycle.
REQ-027 read_pixel with data_available low: ignored, FIFO unchanged, underflow set.
REQ-028 Simultaneous accepted write and pop: both performed, ocupacion unchanged; applies when full (no overflow).
REQ-029 Write into empty FIFO is not bypassed: data_available rises the cycle after the write.
REQ-030 Each accepted pop increments columna; at ancho_imagen-1 columna wraps to 0 and fila increments.
REQ-031 Pop at columna=ancho-1, fila=alto-1: state -> FIN, frame_done high during FIN, columna/fila cleared to 0.
REQ-032 Pixels remaining in FIFO after frame end are retained for the next frame.
REQ-033 Read/write pointers wrap modulo PROFUNDIDAD; fill count never exceeds PROFUNDIDAD.
REQ-034 pixel_entrada holds the last head value when empty; content is don't-care, not checked.

Reset
REQ-035 reset asserted: state IDLE, FIFO empty, ocupacion 0, pixel_entrada 0, columna/fila 0, all flags and pulses 0, dimensions 0.
REQ-036 reset mid-frame discards FIFO contents and frame progress immediately, no frame_done.
REQ-037 Flags overflow/underflow clear only by reset.

Structure
REQ-038 Shared package holds state enum (IDLE, ACTIVO, FIN) and dimension width constant (10).
REQ-039 Storage and pointers in sub-module fifo_pixeles (FWFT, full/empty/count); frame FSM and counters in top.

Verification
REQ-040 Prefill 4 pixels 10,20,30,40, iniciar with 2x2 -> data_available next cycle, pops yield 10,20,30,40, frame_done once after 4th pop, IDLE after.
REQ-041 Write 16 pixels then a 17th (depth 16) -> fifo_full=1, ocupacion=16, overflow=1, 17th value never served.
REQ-042 Full FIFO, ACTIVO, write+pop same cycle -> ocupacion stays 16, overflow stays 0, order preserved.
REQ-043 read_pixel in IDLE with 3 stored pixels -> no pop, ocupacion 3, underflow=1.
REQ-044 Frame 3x2 with continuous pops -> columna 0,1,2,0,1,2, fila 0,0,0,1,1,1, frame_done after 6th pop.
REQ-045 reset pulse after 5 pops of a 4x4 frame -> all outputs at reset values, no frame_done, new iniciar restarts at 0,0.
